// File: rtl/systolic_pkg.sv
// Shared types and helpers for the systolic array edge feeder.
package systolic_pkg;

  localparam int DATA_SIZE_DEFAULT = 8;
  localparam int OFFSET = 1 << (DATA_SIZE_DEFAULT - 1);

  typedef enum logic [1:0] {
    IDLE,
    CLEAR,
    STREAM,
    FLUSH
  } feeder_state_e;

  // Flips bit 'msb' of x, which maps a two's-complement value of width msb+1
  // onto offset-binary (adds 2^msb modulo 2^(msb+1)). Callers keep the low
  // msb+1 bits of the result.
  function automatic logic [63:0] ob_encode(input logic [63:0] x, input int msb);
    return x ^ (64'd1 << msb);
  endfunction

endpackage

// File: rtl/skew_line.sv
// Fixed-depth register chain used to delay one lane of the feeder.
module skew_line #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 1
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic [WIDTH-1:0] d_i,
  output logic [WIDTH-1:0] q_o
);

  logic [WIDTH-1:0] stage_q [DEPTH];

  // Shift data one stage per clock; reset clears every stage to zero.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      for (int s = 0; s < DEPTH; s++) begin
        stage_q[s] <= '0;
      end
    end else begin
      stage_q[0] <= d_i;
      for (int s = 1; s < DEPTH; s++) begin
        stage_q[s] <= stage_q[s-1];
      end
    end
  end

  assign q_o = stage_q[DEPTH-1];

endmodule

// File: rtl/systolic_input_feeder.sv
// West/north edge feeder for an N x N systolic PE array: accepts one k-slice
// per beat, offset-encodes every lane and skews lane i by i extra cycles.
module systolic_input_feeder
  import systolic_pkg::*;
#(
  parameter int data_size  = DATA_SIZE_DEFAULT,
  parameter int N          = 4,
  parameter int OFFSET_ENC = 1
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  start,
  output logic                  busy,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic                  in_last,
  input  logic [N*data_size-1:0] in_a_vec,
  input  logic [N*data_size-1:0] in_b_vec,
  output logic [N*data_size-1:0] a_out,
  output logic [N*data_size-1:0] b_out,
  output logic                  pe_clear,
  output logic                  done
);

  localparam int CNT_W = $clog2(2 * N);
  localparam logic [CNT_W-1:0] FLUSH_LOAD = CNT_W'(2 * N - 1);

  feeder_state_e    state_q, state_d;
  logic [CNT_W-1:0] flushCnt_q, flushCnt_d;
  logic             done_q, done_d;
  logic             accept;

  // Lane encoder: offset-binary when enabled, otherwise the raw element.
  function automatic logic [data_size-1:0] encLane(input logic [data_size-1:0] x);
    logic [63:0] wide;
    wide = ob_encode(64'(x), data_size - 1);
    return (OFFSET_ENC != 0) ? wide[data_size-1:0] : x;
  endfunction

  // State, flush counter and the registered done pulse.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q    <= IDLE;
      flushCnt_q <= '0;
      done_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      flushCnt_q <= flushCnt_d;
      done_q     <= done_d;
    end
  end

  // Next-state logic: the flush counter covers the skew plus the array traversal.
  always_comb begin
    state_d    = state_q;
    flushCnt_d = flushCnt_q;
    done_d     = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (start) state_d = CLEAR;
      end
      CLEAR: begin
        state_d = STREAM;
      end
      STREAM: begin
        if (in_valid && in_last) begin
          flushCnt_d = FLUSH_LOAD;
          state_d    = FLUSH;
        end
      end
      FLUSH: begin
        if (flushCnt_q == '0) begin
          done_d  = 1'b1;
          state_d = IDLE;
        end else begin
          flushCnt_d = flushCnt_q - CNT_W'(1);
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // Outputs decoded purely from the registered state, so in_ready never sees in_valid.
  always_comb begin
    busy     = (state_q != IDLE);
    in_ready = (state_q == STREAM);
    pe_clear = (state_q == CLEAR);
  end

  assign accept = in_ready & in_valid;
  assign done   = done_q;

  // Lane i gets i+1 stages; idle cycles inject zeros so lanes stay aligned.
  for (genvar i = 0; i < N; i++) begin : g_lane
    logic [data_size-1:0] stageA, stageB;

    assign stageA = accept ? encLane(in_a_vec[i*data_size +: data_size]) : '0;
    assign stageB = accept ? encLane(in_b_vec[i*data_size +: data_size]) : '0;

    skew_line #(
      .WIDTH(data_size),
      .DEPTH(i + 1)
    ) u_skew_a (
      .clk_i (clk),
      .rst_ni(reset),
      .d_i   (stageA),
      .q_o   (a_out[i*data_size +: data_size])
    );

    skew_line #(
      .WIDTH(data_size),
      .DEPTH(i + 1)
    ) u_skew_b (
      .clk_i (clk),
      .rst_ni(reset),
      .d_i   (stageB),
      .q_o   (b_out[i*data_size +: data_size])
    );
  end

endmodule
